// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, LFSR constants and key index helpers for the keypad emulator
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_BOUNCE   = 2'd1,
    HELD           = 2'd2,
    RELEASE_BOUNCE = 2'd3
  } emu_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 expressed as Fibonacci taps on q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Key index is row*4 + column, matching the scanner's decoder
  function automatic logic [1:0] key_row(input logic [3:0] key);
    return key[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return key[1:0];
  endfunction

  function automatic logic [3:0] col_onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// rtl/keypad_emulator_if.sv - command port plus row-drive/column-sense bundle of the keypad emulator
interface keypad_emulator_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_press;
  logic [3:0] cmd_key;
  logic [3:0] row;
  logic [3:0] col;
  logic       held;
  logic       dropped;

  modport master (
    output cmd_valid, cmd_press, cmd_key, row,
    input  cmd_ready, col, held, dropped
  );

  modport slave (
    input  cmd_valid, cmd_press, cmd_key, row,
    output cmd_ready, col, held, dropped
  );

endinterface

// File: rtl/keypad_emulator_lfsr8.sv
// rtl/keypad_emulator_lfsr8.sv - 8-bit Fibonacci LFSR that produces the contact-bounce pattern
module lfsr8
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= LFSR_SEED;
    end else if (en) begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - passive 4x4 keypad model with commanded press/release and LFSR contact bounce
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 6
) (
  input  logic               clk,
  input  logic               reset,
  keypad_emulator_if.slave   bus
);

  localparam logic [7:0] LP_BOUNCE = 8'(BOUNCE_CYCLES);

  emu_state_t r_state;
  logic       r_contact;
  logic [3:0] r_key;
  logic [7:0] r_count;
  logic       r_held;
  logic       r_dropped;

  logic       w_ready;
  logic       w_accept;
  logic       w_bouncing;
  logic [7:0] w_lfsr;
  logic [7:0] w_lfsr_next;
  logic [3:0] w_col;

  assign w_bouncing  = (r_state == PRESS_BOUNCE) || (r_state == RELEASE_BOUNCE);
  assign w_ready     = !reset && ((r_state == IDLE) || (r_state == HELD));
  assign w_accept    = bus.cmd_valid && w_ready;
  assign w_lfsr_next = lfsr_step(w_lfsr);

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (w_bouncing),
    .q     (w_lfsr)
  );

  // Contact tracks the LFSR value present during each bounce cycle: on entry the
  // LFSR is idle so its current bit applies, inside the burst it steps with us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_contact <= 1'b0;
      r_key     <= 4'h0;
      r_count   <= 8'd0;
      r_held    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.cmd_press) begin
              r_state   <= PRESS_BOUNCE;
              r_count   <= LP_BOUNCE;
              r_key     <= bus.cmd_key;
              r_contact <= w_lfsr[0];
            end else begin
              r_dropped <= 1'b1;
            end
          end
        end
        HELD: begin
          if (w_accept) begin
            if (!bus.cmd_press) begin
              r_state   <= RELEASE_BOUNCE;
              r_count   <= LP_BOUNCE;
              r_contact <= w_lfsr[0];
              r_held    <= 1'b0;
            end else begin
              r_dropped <= 1'b1;
            end
          end
        end
        PRESS_BOUNCE, RELEASE_BOUNCE: begin
          r_count <= r_count - 8'd1;
          if (r_count <= 8'd1) begin
            r_state   <= (r_state == PRESS_BOUNCE) ? HELD : IDLE;
            r_contact <= (r_state == PRESS_BOUNCE);
            r_held    <= (r_state == PRESS_BOUNCE);
          end else begin
            r_contact <= w_lfsr_next[0];
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Only the latched key's row matters; the scanner's synchronizer registers col
  always_comb begin
    w_col = 4'b0000;
    if (r_contact && bus.row[key_row(r_key)]) begin
      w_col = col_onehot(key_col(r_key));
    end
  end

  assign bus.col       = w_col;
  assign bus.cmd_ready = w_ready;
  assign bus.held      = r_held;
  assign bus.dropped   = r_dropped;

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable model of the 4x4 matrix keypad. It is the passive end of the row-scan/column-sense interface: it watches the row drive from the scanner and returns column sense for one emulated key. A command port presses and releases keys. Each press and release includes a deterministic pseudo-random contact-bounce burst, so the scanner's debounce and FSM can be exercised on hardware or in simulation without a physical keypad.

## Interface
- BOUNCE_CYCLES, 6: length of each bounce burst in clk cycles; legal range 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_press  in  1  1 = press, 0 = release.
- cmd_key  in  4  key index = row*4 + column; row in [3:2], column in [1:0]. Sampled for press only.
- row  in  4  row drive from the scanner, active-high; any pattern is legal.
- col  out  4  column sense returned to the scanner, active-high.
- held  out  1  emulated key is in stable contact.
- dropped  out  1  one-cycle pulse when an accepted command has no effect.

## Operation
- FSM states, shared enum: IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE.
- Registered `contact` bit:
  - 0 in IDLE.
  - 1 in HELD.
  - lfsr[0] in both bounce states.
- Registered key latch `key_q` (4 bits), loaded from cmd_key when a press is accepted.
- col is combinational from row and the registered contact state: col = (contact && row[key_q[3:2]]) ? onehot(key_q[1:0]) : 4'b0000.
  - Other rows are ignored, so multi-hot row drive affects col only through row[key_q[3:2]].
  - row = 0 gives col = 0.
- cmd_ready = !reset && (state == IDLE || state == HELD). It is 0 during both bounce states.
- A command is accepted on a rising clk edge with cmd_valid && cmd_ready.
- Transitions:
  - IDLE + accepted press → PRESS_BOUNCE; bounce counter loaded with BOUNCE_CYCLES.
  - IDLE + accepted release → stay IDLE; dropped = 1 next cycle.
  - HELD + accepted release → RELEASE_BOUNCE; counter loaded with BOUNCE_CYCLES. The release always applies to key_q; cmd_key is ignored.
  - HELD + accepted press → stay HELD; key_q unchanged; dropped = 1 next cycle.
  - PRESS_BOUNCE: counter decrements each cycle. On the cycle it reads 1 → HELD.
  - RELEASE_BOUNCE: same countdown. On the cycle it reads 1 → IDLE.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Seed 8'hA5 at reset.
  - Advances only in bounce states, one step per cycle.
  - The bounce sequence therefore depends only on the number of bounce cycles elapsed since reset.
- held = (state == HELD), registered.

## Timing
- Reset values, applied immediately on assertion: state IDLE, contact 0, col 0, key_q 0, held 0, dropped 0, LFSR 8'hA5, counter 0, cmd_ready 0.
- Press accepted at edge N:
  - Cycles N+1 .. N+BOUNCE_CYCLES: PRESS_BOUNCE; contact = LFSR bits.
  - From N+BOUNCE_CYCLES+1: HELD; contact = 1; held = 1.
- Release has the same latency: contact = 0 and held = 0 from N+BOUNCE_CYCLES+1. held drops at N+1.
- First bounce cycle after reset has contact = 1 (seed bit 0 = 1).
- Row-to-col path is combinational with zero latency. The scanner's synchronizer supplies the registering.
- cmd_valid held high during bounce stalls without loss; the command is accepted on the first ready cycle.
- Reset mid-bounce or mid-HELD: col goes to 0 asynchronously, with no further bounce.

## Structure
- Shared package keypad_pkg holds:
  - emu_state_t enum.
  - LFSR_SEED = 8'hA5 and LFSR_TAPS = 8'b1011_1000 constants.
  - key_row/key_col helper functions.
  - The same key index encoding the decoder uses.
- Sub-module lfsr8 (ports clk, reset, en, q[7:0]) contains the seed/reset logic. The top level contains the FSM, counter, key latch and column decode.

## Test plan
- Reset: assert reset with row = 4'hF → col = 0, held = 0, cmd_ready = 0. Deassert → cmd_ready = 1, col stays 0.
- Press key 4'h6 with BOUNCE_CYCLES = 6 and row = 4'b0010 held constant:
  - col toggles between 4'b0100 and 0 for 6 cycles, first bounce cycle = 4'b0100.
  - From cycle 7 col = 4'b0100 steady and held = 1.
- While holding key 4'h6, rotate row one-hot 0001→0010→0100→1000 each cycle → col = 4'b0100 only when row = 4'b0010, else 0. row = 4'b0110 → col = 4'b0100.
- Release from HELD:
  - cmd_ready = 0 for 6 bounce cycles.
  - col = 0 and held = 0 from cycle 7.
  - cmd_valid held high across the bounce is accepted exactly once.
- Release in IDLE, then press key 4'h3 in HELD of key 4'h6:
  - Each release or press pulses dropped for exactly one cycle.
  - State and key_q are unchanged.
- Assert reset mid PRESS_BOUNCE (cycle 3) → col = 0 immediately. Repeat the same press after reset → bounce sequence identical to the first run.
